// File: rtl/fb_scanout_pkg.sv
// -----------------------------------------------------------------------------
// fb_scanout_pkg
// Shared constants and types for the framebuffer scan-out path and the
// renderer: 640x480@60 VGA timing, 10-bit counter type, 18-bit framebuffer
// address width, and RGB444 pixel field positions inside a framebuffer word.
// No ports (package).
// -----------------------------------------------------------------------------
package fb_scanout_pkg;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned ADDR_W = 18;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [11:0]      rgb444_t;

  // Horizontal timing (pixel ticks)
  localparam cnt_t H_ACTIVE     = 10'd640;
  localparam cnt_t H_FP         = 10'd16;
  localparam cnt_t H_SYNC       = 10'd96;
  localparam cnt_t H_BP         = 10'd48;
  localparam cnt_t H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800
  localparam cnt_t H_SYNC_START = H_ACTIVE + H_FP;                   // 656
  localparam cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC;             // 752

  // Vertical timing (lines)
  localparam cnt_t V_ACTIVE     = 10'd480;
  localparam cnt_t V_FP         = 10'd10;
  localparam cnt_t V_SYNC       = 10'd2;
  localparam cnt_t V_BP         = 10'd33;
  localparam cnt_t V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525
  localparam cnt_t V_SYNC_START = V_ACTIVE + V_FP;                   // 490
  localparam cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC;             // 492

  // Pixel word fields: R=[11:8], G=[7:4], B=[3:0]; upper bits are ignored
  localparam int unsigned PIX_R_MSB = 11;
  localparam int unsigned PIX_R_LSB = 8;
  localparam int unsigned PIX_G_MSB = 7;
  localparam int unsigned PIX_G_LSB = 4;
  localparam int unsigned PIX_B_MSB = 3;
  localparam int unsigned PIX_B_LSB = 0;
  localparam int unsigned PIX_RGB_W = 12;

endpackage

// File: rtl/fb_scanout_if.sv
// -----------------------------------------------------------------------------
// fb_scanout_if
// Synchronous framebuffer read port.
//   fb_re    : read enable (from scan-out)
//   fb_addr  : linear word address y*W + x (from scan-out)
//   fb_rdata : read data, valid 1 clk after fb_re, held until next fb_re
// Modports: master = scan-out side, slave = memory side.
// -----------------------------------------------------------------------------
interface fb_scanout_if #(
  parameter int unsigned PIX_BITS = 16
);
  import fb_scanout_pkg::*;

  logic                fb_re;
  logic [ADDR_W-1:0]   fb_addr;
  logic [PIX_BITS-1:0] fb_rdata;

  modport master (output fb_re, output fb_addr, input  fb_rdata);
  modport slave  (input  fb_re, input  fb_addr, output fb_rdata);

endinterface

// File: rtl/fb_scanout_line_buffer.sv
// -----------------------------------------------------------------------------
// fb_line_buffer
// One-write/one-read line store with synchronous read; the read data register
// holds its value while re_i is low. Used by fb_scanout only when
// FB_SCANOUT_LINEBUF_EN is defined.
//   clk, rst          : clock, asynchronous active-high reset (read register)
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i      : read request, data on rdata_o one clk later
//   rdata_o           : registered read data
// -----------------------------------------------------------------------------
module fb_line_buffer #(
  parameter int unsigned DEPTH = 320,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fb_scanout.sv
// -----------------------------------------------------------------------------
// fb_scanout
// Read side of the 320x240 RGB444 framebuffer. Generates 640x480@60 VGA timing,
// fetches each framebuffer pixel and upscales it 2x2 onto the DAC pins.
// Outputs lag the h/v counters by exactly two pix_ce ticks.
// Ports:
//   clk, rst        : system clock, asynchronous active-high reset
//   pix_ce_i        : pixel-clock enable; all state advances only when high
//   fb (master)     : framebuffer read port (fb_re, fb_addr, fb_rdata)
//   vga_hs_o/vs_o   : sync outputs, active level SYNC_POL
//   vga_r/g/b_o     : colour, zero outside the active area
//   vblank_o        : v_cnt >= 480 (counter-aligned)
//   frame_start_o   : one-clk pulse when the counters enter line 480
// Build option: FB_SCANOUT_LINEBUF_EN -- fetch each fb line once on even
// display lines and replay odd lines from a local line buffer.
// -----------------------------------------------------------------------------
module fb_scanout
  import fb_scanout_pkg::*;
#(
  parameter int unsigned W        = 320,
  parameter int unsigned H        = 240,
  parameter int unsigned PIX_BITS = 16,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pix_ce_i,
  fb_scanout_if.master fb,
  output logic         vga_hs_o,
  output logic         vga_vs_o,
  output logic [3:0]   vga_r_o,
  output logic [3:0]   vga_g_o,
  output logic [3:0]   vga_b_o,
  output logic         vblank_o,
  output logic         frame_start_o
);

  if (W * H > (1 << ADDR_W)) begin : g_geometry_check
    $error("fb_scanout: W*H exceeds the framebuffer address space");
  end

  // ---------------------------------------------------------------- stage 0
  cnt_t              h_cnt_q, v_cnt_q;
  logic              active_s0, hs_s0, vs_s0, fetch_s0;
  logic [ADDR_W-1:0] addr_s0;

  assign active_s0 = (h_cnt_q < H_ACTIVE) && (v_cnt_q < V_ACTIVE);
  assign hs_s0     = (h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END);
  assign vs_s0     = (v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END);
  // 2x2 upscale: drop the LSB of both screen coordinates
  assign addr_s0   = ADDR_W'(v_cnt_q[CNT_W-1:1]) * ADDR_W'(W)
                   + ADDR_W'(h_cnt_q[CNT_W-1:1]);

  // ---------------------------------------------------------- stage 1 / 2
  logic                active_q, hs_q, vs_q;
  rgb444_t             rgb_q;
  logic                vga_hs_q, vga_vs_q, frame_start_q;
  logic [PIX_BITS-1:0] pix_word;

`ifdef FB_SCANOUT_LINEBUF_EN
  localparam int unsigned LB_AW = $clog2(W);

  logic                lb_re, lb_we_q, from_lb_q;
  logic [LB_AW-1:0]    lb_idx, lb_widx_q;
  logic [PIX_BITS-1:0] lb_rdata;

  assign lb_idx   = LB_AW'(h_cnt_q[CNT_W-1:1]);
  // One access per fb pixel: even display lines read the framebuffer,
  // odd display lines read back the copy captured on the line above.
  assign fetch_s0 = pix_ce_i && active_s0 && !v_cnt_q[0] && !h_cnt_q[0];
  assign lb_re    = pix_ce_i && active_s0 &&  v_cnt_q[0] && !h_cnt_q[0];

  // fb_rdata is valid one clk after fb_re, so the write is delayed one clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lb_we_q   <= 1'b0;
      lb_widx_q <= '0;
    end else begin
      lb_we_q   <= fetch_s0;
      lb_widx_q <= lb_idx;
    end
  end

  fb_line_buffer #(
    .DEPTH (W),
    .WIDTH (PIX_BITS)
  ) u_line_buffer (
    .clk     (clk),
    .rst     (rst),
    .we_i    (lb_we_q),
    .waddr_i (lb_widx_q),
    .wdata_i (fb.fb_rdata),
    .re_i    (lb_re),
    .raddr_i (lb_idx),
    .rdata_o (lb_rdata)
  );

  assign pix_word = from_lb_q ? lb_rdata : fb.fb_rdata;
`else
  assign fetch_s0 = pix_ce_i && active_s0;
  assign pix_word = fb.fb_rdata;
`endif

  assign fb.fb_re   = fetch_s0 && !rst;
  assign fb.fb_addr = addr_s0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      active_q      <= 1'b0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      rgb_q         <= '0;
      vga_hs_q      <= ~SYNC_POL;
      vga_vs_q      <= ~SYNC_POL;
      frame_start_q <= 1'b0;
`ifdef FB_SCANOUT_LINEBUF_EN
      from_lb_q     <= 1'b0;
`endif
    end else begin
      frame_start_q <= 1'b0;
      if (pix_ce_i) begin
        if (h_cnt_q == H_TOTAL - 1'b1) begin
          h_cnt_q       <= '0;
          v_cnt_q       <= (v_cnt_q == V_TOTAL - 1'b1) ? '0 : v_cnt_q + 1'b1;
          frame_start_q <= (v_cnt_q == V_ACTIVE - 1'b1);
        end else begin
          h_cnt_q <= h_cnt_q + 1'b1;
        end
        active_q <= active_s0;
        hs_q     <= hs_s0;
        vs_q     <= vs_s0;
`ifdef FB_SCANOUT_LINEBUF_EN
        from_lb_q <= v_cnt_q[0];
`endif
        rgb_q    <= active_q ? pix_word[PIX_RGB_W-1:0] : '0;
        vga_hs_q <= hs_q ? SYNC_POL : ~SYNC_POL;
        vga_vs_q <= vs_q ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

  // Upper framebuffer word bits carry no colour
  logic unused_pix_hi;
  assign unused_pix_hi = ^pix_word[PIX_BITS-1:PIX_RGB_W];

  assign vga_r_o       = rgb_q[PIX_R_MSB:PIX_R_LSB];
  assign vga_g_o       = rgb_q[PIX_G_MSB:PIX_G_LSB];
  assign vga_b_o       = rgb_q[PIX_B_MSB:PIX_B_LSB];
  assign vga_hs_o      = vga_hs_q;
  assign vga_vs_o      = vga_vs_q;
  assign vblank_o      = (v_cnt_q >= V_ACTIVE);
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_fb_scanout.sv
// -----------------------------------------------------------------------------
// tb_fb_scanout
// Self-checking bench for fb_scanout. The reference is the screen position
// reached after k pix_ce ticks: outputs show position k-2, the read port shows
// position k, and colours come from the bench's own framebuffer content
// function evaluated at (v/2)*W + h/2.
// -----------------------------------------------------------------------------
module tb_fb_scanout;

  localparam int unsigned W     = 320;
  localparam int unsigned HT    = 800;
  localparam int unsigned VT    = 525;
  localparam int unsigned FRAME = HT * VT;
  localparam int unsigned MAXF  = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_ce = 1'b0;
  logic       vga_hs, vga_vs, vblank, frame_start;
  logic [3:0] vga_r, vga_g, vga_b;

  fb_scanout_if #(.PIX_BITS(16)) fb_bus ();

  fb_scanout #(
    .W        (320),
    .H        (240),
    .PIX_BITS (16),
    .SYNC_POL (1'b0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pix_ce_i      (pix_ce),
    .fb            (fb_bus),
    .vga_hs_o      (vga_hs),
    .vga_vs_o      (vga_vs),
    .vga_r_o       (vga_r),
    .vga_g_o       (vga_g),
    .vga_b_o       (vga_b),
    .vblank_o      (vblank),
    .frame_start_o (frame_start)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned k        = 0;   // pix_ce ticks since reset release
  int unsigned mode     = 0;   // 0: data=addr, 1: all ones, 2: hashed
  logic [31:0] seed;

  // hsync shape tracking (full-rate phases only)
  bit          full_rate = 1'b1;
  bit          hs_prev   = 1'b1;
  bit          have_fall = 1'b0;
  int unsigned cyc = 0, last_fall = 0, hs_low = 0;

  function automatic logic [15:0] fdata(input logic [17:0] a);
    logic [31:0] x;
    case (mode)
      0:       fdata = a[15:0];
      1:       fdata = 16'hFFFF;
      default: begin
        x = ({14'd0, a} * 32'h9E3779B1) ^ seed;
        fdata = x[23:8];
      end
    endcase
  endfunction

  // Framebuffer memory: registered read, data held between reads
  always @(posedge clk) begin
    if (fb_bus.fb_re) fb_bus.fb_rdata <= fdata(fb_bus.fb_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (tick %0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  task automatic check_outputs(input logic ce);
    int unsigned p, h, v;
    logic [15:0] w;
    logic [11:0] er;
    logic        ehs, evs;
    chk("frame_start", frame_start, ce && (k % FRAME == 480 * HT));
    if (k < 2) begin
      er = '0; ehs = 1'b1; evs = 1'b1; h = 0; v = 0;
    end else begin
      p   = (k - 2) % FRAME;
      h   = p % HT;
      v   = p / HT;
      w   = fdata(18'((v / 2) * W + h / 2));
      er  = (h < 640 && v < 480) ? w[11:0] : 12'h000;
      ehs = !(h >= 656 && h < 752);
      evs = !(v >= 490 && v < 492);
    end
    chk("rgb", {vga_r, vga_g, vga_b}, er);
    chk("vga_hs", vga_hs, ehs);
    chk("vga_vs", vga_vs, evs);
    if (mode == 0 && k >= 2 && h == 3 && v == 5)
      chk("px_h3_v5", {vga_r, vga_g, vga_b}, 12'h281);
    cyc++;
    if (full_rate) begin
      if (hs_prev && !vga_hs) begin
        if (have_fall) chk("hs_period", cyc - last_fall, HT);
        have_fall = 1'b1;
        last_fall = cyc;
        hs_low    = 0;
      end
      if (!vga_hs) hs_low++;
      if (!hs_prev && vga_hs && have_fall) chk("hs_low_len", hs_low, 96);
    end
    hs_prev = vga_hs;
  endtask

  // One clk: drive pix_ce, check read port, clock, check outputs
  task automatic cycle(input logic ce);
    int unsigned p, h, v;
    logic        exp_re;
    if (failures >= MAXF) return;
    pix_ce = ce;
    #1;
    p = k % FRAME;
    h = p % HT;
    v = p / HT;
    exp_re = ce && h < 640 && v < 480;
`ifdef FB_SCANOUT_LINEBUF_EN
    exp_re = exp_re && (v % 2 == 0) && (h % 2 == 0);
`endif
    chk("fb_re", fb_bus.fb_re, exp_re);
    if (exp_re) chk("fb_addr", fb_bus.fb_addr, (v / 2) * W + h / 2);
    chk("vblank", vblank, v >= 480);
    @(posedge clk);
    if (ce) k++;
    #1;
    check_outputs(ce);
  endtask

  // Asynchronous reset pulse, checked before any clock edge sees it
  task automatic do_reset();
    #2;
    rst    = 1'b1;
    pix_ce = 1'b1;
    #1;
    chk("rst_fb_re", fb_bus.fb_re, 1'b0);
    chk("rst_fb_addr", fb_bus.fb_addr, 0);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    chk("rst_hs", vga_hs, 1'b1);
    chk("rst_vs", vga_vs, 1'b1);
    chk("rst_vblank", vblank, 1'b0);
    chk("rst_frame_start", frame_start, 1'b0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    k         = 0;
    hs_prev   = 1'b1;
    have_fall = 1'b0;
  endtask

  initial begin
    seed = $urandom;
    fb_bus.fb_rdata = '0;
    @(posedge clk);
    #1;

    // data = address, continuous pixel clock
    mode = 0; full_rate = 1'b1;
    do_reset();
    repeat (6 * HT + 20) cycle(1'b1);

    // all-ones data: only [11:0] may appear, blanking forces zero
    mode = 1;
    do_reset();
    repeat (2 * HT + 20) cycle(1'b1);

    // hashed data, pix_ce every 4th clk
    mode = 2; full_rate = 1'b0;
    do_reset();
    for (int i = 0; i < int'(2 * HT * 4 + 40); i++) cycle(i % 4 == 3);

    // hashed data, random pix_ce spacing
    do_reset();
    for (int i = 0; i < int'(3 * HT * 3); i++) cycle($urandom_range(0, 2) == 0);

    // reset pulsed mid-frame at (h=300, v=3), then restart from address 0
    full_rate = 1'b1;
    seed = $urandom;
    do_reset();
    while (k < 3 * HT + 300 && failures < MAXF) cycle(1'b1);
    do_reset();
    repeat (2 * HT + 20) cycle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
